stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 72 +++++++
 tb/tb_stream_mux_rr.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux with fixed-select or round-robin grant.
// Define STREAM_MUX_COUNT_EN to add the 16-bit xfer_count output transfer counter.
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_chan
`ifdef STREAM_MUX_COUNT_EN
  ,output logic [15:0]              xfer_count
`endif
);
  logic [SEL_W-1:0] ptr_q, ptr_d, chan_q, chan_d, g, idx;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, found, load, accept;
  // Fixed mode scans every channel but only matches sel, so an out-of-range sel grants nothing.
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = mode ? SEL_W'((int'(ptr_q) + k) % CHANNELS) : SEL_W'(k);
      if (!found && in_valid[idx] && (mode || idx == sel)) begin
        found = 1'b1;
        g = idx;
      end
    end
  end
  assign load = ~valid_q | out_ready;
  assign accept = found & load & ~rst;
  assign in_ready = {{(CHANNELS-1){1'b0}}, accept} << g;
  always_comb begin
    data_d = accept ? in_data[g*WIDTH +: WIDTH] : data_q;
    chan_d = accept ? g : chan_q;
    valid_d = accept | (valid_q & ~out_ready);
    ptr_d = (accept & mode) ? ((int'(g) == CHANNELS-1) ? '0 : g + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      chan_q <= '0;
      valid_q <= 1'b0;
      ptr_q <= '0;
    end else begin
      data_q <= data_d;
      chan_q <= chan_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_data = data_q;
  assign out_chan = chan_q;
  assign out_valid = valid_q;
`ifdef STREAM_MUX_COUNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (valid_q & out_ready) cnt_q <= cnt_q + 16'd1;
  end
  assign xfer_count = cnt_q;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed self-checking bench for stream_mux_rr (CHANNELS=4, WIDTH=8).
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] in_data;
  logic [3:0] in_valid, in_ready;
  logic mode, out_valid, out_ready;
  logic [1:0] sel, out_chan;
  logic [7:0] out_data;
`ifdef STREAM_MUX_COUNT_EN
  logic [15:0] xfer_count;
`endif
  int checks = 0;
  int failures = 0;

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_chan(out_chan)
`ifdef STREAM_MUX_COUNT_EN
    , .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b1; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h33A52211;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_chan !== 2'd0) begin failures++; $display("FAIL reset_chan got=%0d exp=0", out_chan); end
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", in_ready); end
    step();
    rst = 1'b0; in_valid = 4'h0;
  endtask

  task automatic test_fixed();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; out_ready = 1'b1; in_data = 32'h33A52211;
    #1;
    checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
    step();
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL fixed_data got=%h exp=a5", out_data); end
    checks++; if (out_chan !== 2'd2) begin failures++; $display("FAIL fixed_chan got=%0d exp=2", out_chan); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fixed_valid got=%b exp=1", out_valid); end
    sel = 2'd3; in_valid = 4'b0111;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL fixed_noready got=%b exp=0000", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fixed_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_rr_fair();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'hA5; exp_d[3] = 8'h33;
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (out_chan !== 2'(i % 4)) begin failures++; $display("FAIL rr_chan[%0d] got=%0d exp=%0d", i, out_chan, i % 4); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_data !== exp_d[i % 4]) begin failures++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, out_data, exp_d[i % 4]); end
    end
  endtask

  task automatic test_rr_skip();
    logic [3:0] exp_r [4];
    logic [1:0] exp_c [4];
    exp_r[0] = 4'b0010; exp_r[1] = 4'b1000; exp_r[2] = 4'b0010; exp_r[3] = 4'b1000;
    exp_c[0] = 2'd1; exp_c[1] = 2'd3; exp_c[2] = 2'd1; exp_c[3] = 2'd3;
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== exp_r[i]) begin failures++; $display("FAIL skip_ready[%0d] got=%b exp=%b", i, in_ready, exp_r[i]); end
      step();
      checks++; if (out_chan !== exp_c[i]) begin failures++; $display("FAIL skip_chan[%0d] got=%0d exp=%0d", i, out_chan, exp_c[i]); end
    end
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1; in_data = 32'h33A5223C;
    step();
    checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL bp_load got=%h exp=3c", out_data); end
    out_ready = 1'b0; in_data = 32'h33A5225A;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
      step();
      checks++; if (out_data !== 8'h3C || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold[%0d] got=%h/%b exp=3c/1", i, out_data, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin failures++; $display("FAIL bp_nobubble got=%h/%b exp=5a/1", out_data, out_valid); end
    in_valid = 4'h0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1; in_data = 32'h33A52211;
    step();
    checks++; if (out_chan !== 2'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=1/1", out_chan, out_valid); end
    out_ready = 1'b0; in_valid = 4'hF;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin failures++; $display("FAIL mid_async got=%b/%h/%0d exp=0/00/0", out_valid, out_data, out_chan); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL mid_ready_in_rst got=%b exp=0000", in_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL mid_ptr0 got=%b exp=0001", in_ready); end
    step();
    checks++; if (out_chan !== 2'd0 || out_data !== 8'h11) begin failures++; $display("FAIL mid_first got=%0d/%h exp=0/11", out_chan, out_data); end
  endtask

`ifdef STREAM_MUX_COUNT_EN
  task automatic test_count();
    rst = 1'b1;
    #1;
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL cnt_reset got=%0d exp=0", xfer_count); end
    step();
    rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    repeat (2) step();
    checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL cnt_one got=%0d exp=1", xfer_count); end
    repeat (65534) step();
    checks++; if (xfer_count !== 16'd65535) begin failures++; $display("FAIL cnt_max got=%0d exp=65535", xfer_count); end
    step();
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL cnt_wrap got=%0d exp=0", xfer_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_skip();
    test_back_to_back();
    test_reset_mid();
`ifdef STREAM_MUX_COUNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
